// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit bank of set/reset flags between NREQ requesters.
// Each grant applies the winner's set/reset masks, then a HOLD-cycle lockout blocks further grants.
module sr_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  set_mask,
    input  logic [NREQ*WIDTH-1:0]  rst_mask,
    output logic [NREQ-1:0]        gnt,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qbar,
    output logic                   busy,
    output logic                   conflict,
    output logic [7:0]             conflict_cnt
);

    localparam int         PW        = $clog2(NREQ);
    localparam logic [3:0] HOLD_LAST = 4'((HOLD > 0) ? HOLD - 1 : 0);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  bank_q, bank_d;
    logic              conflict_q, conflict_d;
    logic [7:0]        ccnt_q, ccnt_d;

    logic [NREQ-1:0]   elig;
    logic [PW-1:0]     win;
    logic [WIDTH-1:0]  win_set, win_rst;
    logic              win_conflict;

    // First eligible index at or after ptr, wrapping modulo NREQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] e, input logic [PW-1:0] p);
        logic [PW-1:0] w;
        logic          found;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(p) + i) % NREQ);
            if (!found && e[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        return w;
    endfunction

    // Masking the live grant stops a requester being granted twice when HOLD=0.
    assign elig         = req & ~gnt_q;
    assign win          = rr_pick(elig, ptr_q);
    assign win_set      = set_mask[win*WIDTH +: WIDTH];
    assign win_rst      = rst_mask[win*WIDTH +: WIDTH];
    assign win_conflict = |(win_set & win_rst);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        gnt_d      = '0;
        bank_d     = bank_q;
        conflict_d = 1'b0;
        ccnt_d     = ccnt_q;
        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    // set-only bits go high, reset-only bits go low, 11 and 00 hold
                    bank_d     = (bank_q | (win_set & ~win_rst)) & ~(win_rst & ~win_set);
                    gnt_d[win] = 1'b1;
                    ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                    conflict_d = win_conflict;
                    if (win_conflict && ccnt_q != 8'hFF) ccnt_d = ccnt_q + 8'd1;
                    if (HOLD > 0) begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LAST;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            bank_q     <= '0;
            conflict_q <= 1'b0;
            ccnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            bank_q     <= bank_d;
            conflict_q <= conflict_d;
            ccnt_q     <= ccnt_d;
        end
    end

    assign gnt          = gnt_q;
    assign q            = bank_q;
    assign qbar         = ~bank_q;
    assign busy         = (state_q == S_HOLD);
    assign conflict     = conflict_q;
    assign conflict_cnt = ccnt_q;

endmodule

// File: doc/sr_bank_arbiter.md
Name: sr_bank_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit bank of set/reset flag flip-flops between NREQ requesters.
- Each granted request applies per-bit set and reset masks to the bank with SR semantics.
- Both-asserted bits hold their value and are reported as conflicts; they never go to X.
- A programmable lockout (HOLD) follows every update. The block sits between control agents and the shared status/flag bank.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, flag bank width in bits
HOLD, 1, lockout cycles after each applied update (0..15); 0 allows back-to-back updates

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  NREQ  per-requester request; held until its gnt bit is seen
set_mask  input  NREQ*WIDTH  requester i set mask in bits [i*WIDTH +: WIDTH]
rst_mask  input  NREQ*WIDTH  requester i reset mask in bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot, one-cycle grant pulse (registered)
q  output  WIDTH  flag bank state (registered)
qbar  output  WIDTH  bitwise ~q
busy  output  1  high while in HOLD state
conflict  output  1  one-cycle pulse: applied masks had any bit with set=reset=1
conflict_cnt  output  8  saturating count of conflicting updates

Behaviour:
- Reset (rst=1 at posedge, dominant over everything):
  - q=0, qbar=all ones, gnt=0, busy=0, conflict=0, conflict_cnt=0.
  - Round-robin pointer ptr=0, lockout counter=0, state=IDLE.
  - Reset mid-HOLD aborts the lockout. A request pending during reset is not granted that cycle.
- FSM states: IDLE, HOLD.
- IDLE:
  - Eligible set = req & ~gnt. Masking the requester whose gnt is currently high prevents a double grant when HOLD=0.
  - If the eligible set is non-empty, the winner is the first eligible index searching ptr, ptr+1, ... with wrap modulo NREQ.
  - At that posedge:
    - q updated from the winner's masks.
    - gnt[winner]<=1.
    - ptr<=(winner+1) mod NREQ.
    - conflict<=|(set&rst).
    - conflict_cnt increments if conflict, saturating at 255.
  - Next state: if HOLD>0, state<=HOLD with lockout counter<=HOLD-1; otherwise stay IDLE.
  - If the eligible set is empty: no change, gnt<=0, conflict<=0.
- HOLD:
  - busy=1, gnt<=0 after the first cycle, conflict<=0.
  - No grants are issued. The counter decrements each cycle; at 0, state<=IDLE.
  - The lockout therefore lasts exactly HOLD cycles.
  - Requests arriving during HOLD stay pending and are arbitrated in the first IDLE cycle.
- Per-bit update rule (s, r from the winner's masks):
  - 00: hold.
  - 10: q=1.
  - 01: q=0.
  - 11: hold, and counts as a conflict.
- Latency: a request sampled at edge N produces gnt and new q visible after edge N. The requester must drop req in the cycle it sees gnt. A req still high after that cycle is treated as a new request.
- Throughput: one update per HOLD+1 cycles maximum.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0. The worst-case wait is (NREQ-1)*(HOLD+1) cycles.
- Masks are sampled only from the winner at its grant edge. The masks of requesters that did not win are ignored.
- gnt is always one-hot or zero. qbar is always exactly ~q, including at reset.

Test Plan:
- Reset then idle: rst high 2 cycles, req=0 -> q=8'h00, qbar=8'hFF, gnt=0, busy=0, conflict_cnt=0.
- Single set/reset: HOLD=1, req0 with set=8'h0F, rst=0 -> gnt=4'b0001 one cycle, q=8'h0F, busy high 1 cycle. Then req0 with rst=8'h03 -> q=8'h0C.
- Round-robin: HOLD=0, req=4'b1111 held (each drops on gnt, re-raises the next cycle) -> gnt sequence 0001,0010,0100,1000,0001. No requester is granted in two consecutive cycles.
- Conflict: req2 with set=8'hF0, rst=8'h30, q=8'h0C -> q=8'hCC, conflict pulses 1 cycle, conflict_cnt=1. Repeat 300 times -> conflict_cnt=255.
- Lockout: HOLD=3, req1 is granted and req3 is raised in the next cycle -> busy high 3 cycles, gnt[3] asserted exactly 4 cycles after gnt[1].
- Reset mid-operation: HOLD=5, assert rst in the 2nd HOLD cycle with req0 high -> next cycle state IDLE, q=0, no gnt that cycle. req0 is granted on the first edge after rst drops.
